// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared constants for the EX-stage branch/jump redirect controller:
// FSM state encoding, address width and default statistics counter width.
package branch_redirect_ctrl_pkg;

  localparam int ADDR_W        = 32;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter: increments by one per cycle with i_inc high,
// sticks at all-ones instead of wrapping; asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max = &r_cnt;
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage redirect controller: flushes IF/ID and ID/EX on a taken branch or jump,
// then steers the PC mux to the latched, halfword-aligned target for one unstalled cycle.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              branch,
  input  logic              branch_out,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              stall,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              busy,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              w_accept;
  logic              w_redirect;

  // rst gates acceptance so no flush can leak out while reset is held.
  assign w_accept    = (r_state == IDLE) && ex_valid && !stall && !rst;
  assign w_redirect  = w_accept && (jump || (branch && branch_out));
  assign redirect_pc = r_redirect_pc;

  always_comb begin
    w_state_nxt = r_state;
    pc_sel      = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_redirect) begin
          flush_ifid  = 1'b1;
          flush_idex  = 1'b1;
          w_state_nxt = REDIR;
        end
      end
      REDIR: begin
        pc_sel     = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        busy       = 1'b1;
        if (!stall) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redirect) begin
        r_redirect_pc <= {target[ADDR_W-1:1], 1'b0};
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept && branch),
    .o_cnt (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_redirect),
    .o_cnt (taken_cnt)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: a default-width and a 4-bit-counter instance share
// stimulus; per-cycle expectations from a reference model go through a scoreboard queue.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, branch = 1'b0, branch_out = 1'b0, jump = 1'b0, stall = 1'b0;
  logic [31:0] target = '0;

  logic        pc_sel, flush_ifid, flush_idex, busy;
  logic [31:0] redirect_pc;
  logic [15:0] branch_cnt, taken_cnt;
  logic        pc_sel4, flush_ifid4, flush_idex4, busy4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_cnt4, taken_cnt4;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch(branch), .branch_out(branch_out),
    .jump(jump), .target(target), .stall(stall), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .busy(busy),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_redirect_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .branch(branch), .branch_out(branch_out),
    .jump(jump), .target(target), .stall(stall), .pc_sel(pc_sel4), .redirect_pc(redirect_pc4),
    .flush_ifid(flush_ifid4), .flush_idex(flush_idex4), .busy(busy4),
    .branch_cnt(branch_cnt4), .taken_cnt(taken_cnt4)
  );

  typedef struct packed {
    logic        pc_sel;
    logic        flush_ifid;
    logic        flush_idex;
    logic        busy;
    logic [31:0] pc;
    logic [15:0] bcnt;
    logic [15:0] tcnt;
    logic [3:0]  bcnt4;
    logic [3:0]  tcnt4;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic        m_redir = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [15:0] m_b = '0, m_t = '0;
  logic [3:0]  m_b4 = '0, m_t4 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, queue the model's expectation, compare mid-cycle, advance model.
  task automatic cyc(input logic r, input logic ev, input logic br, input logic bo,
                     input logic jp, input logic [31:0] tg, input logic st);
    exp_t e;
    exp_t got;
    logic acc, red;
    rst = r; ex_valid = ev; branch = br; branch_out = bo; jump = jp; target = tg; stall = st;
    if (r) begin
      m_redir = 1'b0; m_pc = '0; m_b = '0; m_t = '0; m_b4 = '0; m_t4 = '0;
    end
    acc = !r && !m_redir && ev && !st;
    red = acc && (jp || (br && bo));
    e.pc_sel     = m_redir;
    e.busy       = m_redir;
    e.flush_ifid = m_redir || red;
    e.flush_idex = m_redir || red;
    e.pc = m_pc; e.bcnt = m_b; e.tcnt = m_t; e.bcnt4 = m_b4; e.tcnt4 = m_t4;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("pc_sel",      {31'd0, pc_sel},      {31'd0, got.pc_sel});
      check("flush_ifid",  {31'd0, flush_ifid},  {31'd0, got.flush_ifid});
      check("flush_idex",  {31'd0, flush_idex},  {31'd0, got.flush_idex});
      check("busy",        {31'd0, busy},        {31'd0, got.busy});
      check("redirect_pc", redirect_pc,          got.pc);
      check("branch_cnt",  {16'd0, branch_cnt},  {16'd0, got.bcnt});
      check("taken_cnt",   {16'd0, taken_cnt},   {16'd0, got.tcnt});
      check("branch_cnt4", {28'd0, branch_cnt4}, {28'd0, got.bcnt4});
      check("taken_cnt4",  {28'd0, taken_cnt4},  {28'd0, got.tcnt4});
      check("pc_sel4",     {31'd0, pc_sel4},     {31'd0, got.pc_sel});
    end
    @(posedge clk);
    if (!r) begin
      if (m_redir) begin
        if (!st) m_redir = 1'b0;
      end else if (red) begin
        m_redir = 1'b1;
        m_pc    = {tg[31:1], 1'b0};
      end
      if (acc && br) begin
        if (m_b  != 16'hFFFF) m_b  = m_b + 16'd1;
        if (m_b4 != 4'hF)     m_b4 = m_b4 + 4'd1;
      end
      if (red) begin
        if (m_t  != 16'hFFFF) m_t  = m_t + 16'd1;
        if (m_t4 != 4'hF)     m_t4 = m_t4 + 4'd1;
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);  // reset masks a live redirect
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();

    // Taken BEQ
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);  // REDIR ignores EX inputs
    idle();

    // Not-taken branch, bubble with branch bits set
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 1'b0);

    // JALR to odd target
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2003, 1'b0);
    idle();
    idle();

    // Stalled in IDLE, then accepted, then REDIR stalled three cycles
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5555, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();

    // Jump and branch together, then back-to-back redirects
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_4010, 1'b0);
    idle();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_6000, 1'b0);
    idle();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_7001, 1'b0);
    idle();
    idle();

    // Reset while in REDIR aborts the redirect
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_8000, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle();
    idle();

    // Saturation: 20 taken branches
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1000 + i * 4, 1'b0);
      idle();
    end
    idle();
    check("sat_branch_cnt4", {28'd0, branch_cnt4}, 32'd15);
    check("sat_taken_cnt4",  {28'd0, taken_cnt4},  32'd15);
    check("wide_branch_cnt", {16'd0, branch_cnt},  32'd20);
    check("wide_taken_cnt",  {16'd0, taken_cnt},   32'd20);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
